// File: rtl/imem_program_loader_pkg.sv
// Shared encoding definitions for the instruction memory writer and the control unit decoder.
package imem_program_loader_pkg;

    localparam int WORD_W = 16;
    localparam int VAL_W  = 12;

    localparam logic [3:0] OP_LOAD    = 4'h0;
    localparam logic [3:0] OP_STORE   = 4'h1;
    localparam logic [3:0] OP_JUMP    = 4'h2;
    localparam logic [3:0] OP_BRANCHZ = 4'h4;
    localparam logic [3:0] OP_TYPEC   = 4'h8;
    localparam logic [3:0] OP_ADDI    = 4'hC;
    localparam logic [3:0] OP_SUBI    = 4'hD;
    localparam logic [3:0] OP_ANDI    = 4'hE;
    localparam logic [3:0] OP_ORI     = 4'hF;

    localparam logic [7:0] FUNC_ADD = 8'b0000_0010;
    localparam logic [7:0] FUNC_SUB = 8'b0000_0100;
    localparam logic [7:0] FUNC_AND = 8'b0000_1000;
    localparam logic [7:0] FUNC_OR  = 8'b0001_0000;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int REG_MSB = 11;
    localparam int REG_LSB = 10;
    localparam int FN_MSB  = 7;
    localparam int FN_LSB  = 0;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_IMM     = 2'b10;
    localparam logic [1:0] ERR_OVF     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_HALT,
        ST_DONE
    } state_e;

    function automatic logic [7:0] func_onehot(input logic [1:0] func);
        case (func)
            2'b00:   return FUNC_ADD;
            2'b01:   return FUNC_SUB;
            2'b10:   return FUNC_AND;
            default: return FUNC_OR;
        endcase
    endfunction

endpackage

// File: rtl/imem_program_loader_if.sv
// Assembler command stream: valid/ready handshake carrying one instruction's fields.
interface imem_program_loader_if;
    import imem_program_loader_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [1:0]       cmd_reg;
    logic [1:0]       cmd_func;
    logic [VAL_W-1:0] cmd_val;
    logic             cmd_last;

    modport master (
        output cmd_valid, cmd_op, cmd_reg, cmd_func, cmd_val, cmd_last,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_reg, cmd_func, cmd_val, cmd_last,
        output cmd_ready
    );

endinterface

// File: rtl/imem_program_loader_instr_encoder.sv
// Maps one assembler command to its 16-bit instruction word and flags illegal input.
// Latency: combinational. Backpressure: none.
module imem_program_loader_instr_encoder
    import imem_program_loader_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [1:0]        rg,
    input  logic [1:0]        func,
    input  logic [VAL_W-1:0]  val,
    output logic [WORD_W-1:0] word,
    output logic              illegal,
    output logic              imm_range_err
);

    always_comb begin
        word          = '0;
        illegal       = 1'b0;
        imm_range_err = 1'b0;
        word[OPC_MSB:OPC_LSB] = op;
        case (op)
            OP_LOAD, OP_STORE, OP_JUMP, OP_BRANCHZ: begin
                word[VAL_W-1:0] = val;
            end
            OP_TYPEC: begin
                word[REG_MSB:REG_LSB] = rg;
                word[FN_MSB:FN_LSB]   = func_onehot(func);
            end
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
                word[REG_MSB:REG_LSB] = rg;
                word[FN_MSB:FN_LSB]   = val[7:0];
                // Immediates are 8 bits; any upper-nibble bit means the assembler overflowed.
                imm_range_err         = |val[VAL_W-1:8];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imem_program_loader.sv
// Writes encoded commands to consecutive imem addresses and closes each program with a self-jump halt.
// Latency: word written the cycle after its handshake; halt follows the last write; done one cycle after halt.
// Backpressure: cmd_ready high only while accepting; one command per cycle, no internal buffering.
module imem_program_loader
    import imem_program_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int BASE   = 0
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    imem_program_loader_if.slave cmd,
    output logic                im_we,
    output logic [ADDR_W-1:0]   im_addr,
    output logic [WORD_W-1:0]   im_wdata,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code,
    output logic [ADDR_W:0]     count
);

    state_e              state, state_nxt;
    logic [ADDR_W-1:0]   wptr;
    logic                cmd_ready_q;
    logic [WORD_W-1:0]   enc_word;
    logic                enc_illegal, enc_imm_err;
    logic                hs, at_end;
    logic                wr_cmd, wr_halt, err_nxt;
    logic [1:0]          err_code_nxt;

    imem_program_loader_instr_encoder u_enc (
        .op            (cmd.cmd_op),
        .rg            (cmd.cmd_reg),
        .func          (cmd.cmd_func),
        .val           (cmd.cmd_val),
        .word          (enc_word),
        .illegal       (enc_illegal),
        .imm_range_err (enc_imm_err)
    );

    assign cmd.cmd_ready = cmd_ready_q;
    assign hs            = cmd.cmd_valid && cmd_ready_q;
    assign at_end        = (wptr == ADDR_W'(DEPTH - 1));

    always_comb begin
        state_nxt    = state;
        wr_cmd       = 1'b0;
        wr_halt      = 1'b0;
        err_nxt      = 1'b0;
        err_code_nxt = err_code;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                if (hs) begin
                    if (enc_illegal) begin
                        err_nxt      = 1'b1;
                        err_code_nxt = ERR_ILLEGAL;
                    end else if (enc_imm_err) begin
                        err_nxt      = 1'b1;
                        err_code_nxt = ERR_IMM;
                    end else if (at_end) begin
                        // Last slot belongs to the halt word, so a legal command here ends the program.
                        err_nxt      = 1'b1;
                        err_code_nxt = ERR_OVF;
                        state_nxt    = ST_HALT;
                    end else begin
                        wr_cmd = 1'b1;
                    end
                    if (cmd.cmd_last) state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                wr_halt   = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            wptr        <= ADDR_W'(BASE);
            cmd_ready_q <= 1'b0;
            im_we       <= 1'b0;
            im_addr     <= ADDR_W'(BASE);
            im_wdata    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
            count       <= '0;
        end else begin
            state       <= state_nxt;
            cmd_ready_q <= (state_nxt == ST_ACCEPT);
            busy        <= (state_nxt != ST_IDLE);
            done        <= (state == ST_DONE);
            im_we       <= 1'b0;
            err         <= 1'b0;
            if (state == ST_IDLE && start) begin
                wptr     <= ADDR_W'(BASE);
                count    <= '0;
                err_code <= ERR_NONE;
            end
            if (wr_cmd) begin
                im_we    <= 1'b1;
                im_addr  <= wptr;
                im_wdata <= enc_word;
                wptr     <= wptr + ADDR_W'(1);
                count    <= count + (ADDR_W + 1)'(1);
            end
            if (wr_halt) begin
                im_we    <= 1'b1;
                im_addr  <= wptr;
                im_wdata <= {OP_JUMP, VAL_W'(wptr)};
                count    <= count + (ADDR_W + 1)'(1);
            end
            if (err_nxt) begin
                err      <= 1'b1;
                err_code <= err_code_nxt;
            end
        end
    end

endmodule
